// File: rtl/space_monsters_game_seq.sv
// -----------------------------------------------------------------------------
// space_monsters_game_seq
//
// Game-flow sequencer for Space Monsters. Tracks the current level out of
// NUM_LEVELS, the remaining lives and a saturating score, and runs a short
// delay between a cleared level and the load of the next one. It sits between
// the block controller (which supplies win / tank_destroyed / kill) and the
// VGA/score display.
//
// Parameters:
//   NUM_LEVELS   levels per game (1..15)
//   LIVES        lives at game start (1..7)
//   SCORE_W      score width in bits
//   LEVEL_BONUS  bonus per cleared level, multiplied by the level number
//   CLEAR_CYCLES cycles spent in CLEAR before the next level loads (>= 1)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   start          one-cycle pulse: begin a game / leave an end screen
//   kill           one-cycle pulse: one monster destroyed
//   win            level cleared (from block controller)
//   tank_destroyed tank hit (from block controller)
//   level          current level, 0 while in START
//   level_load     one-cycle strobe: reinitialise playfield for `level`
//   play_en        high only while playing
//   lives          remaining lives
//   score          current score (saturating)
//   game_won       high in SUCCESS
//   game_over      high in FAILED
//   state          encoded state for debug/display
//   hiscore        best end-of-game score (only with the macro below)
//
// Optional feature: define SPACE_MONSTERS_HISCORE_EN to add the `hiscore`
// output, updated on entry to SUCCESS or FAILED and cleared only by rst.
// -----------------------------------------------------------------------------
module space_monsters_game_seq #(
  parameter int NUM_LEVELS   = 4,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 8,
  parameter int LEVEL_BONUS  = 10,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               kill,
  input  logic               win,
  input  logic               tank_destroyed,
  output logic [3:0]         level,
  output logic               level_load,
  output logic               play_en,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_won,
  output logic               game_over,
  output logic [2:0]         state
`ifdef SPACE_MONSTERS_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_CLEAR   = 3'd3,
    S_DEATH   = 3'd4,
    S_SUCCESS = 3'd5,
    S_FAILED  = 3'd6
  } state_t;

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  // Extra headroom so kill + bonus can never wrap before saturation.
  localparam int SUM_W = SCORE_W + 8;
  localparam logic [SUM_W-1:0] SCORE_MAX_W = {{8{1'b0}}, {SCORE_W{1'b1}}};

  state_t             state_q, state_d;
  logic [CLR_W-1:0]   clr_q, clr_d;
  logic [3:0]         level_d;
  logic [2:0]         lives_d;
  logic [SCORE_W-1:0] score_d;
  logic [SUM_W-1:0]   sum_w;
  logic [SCORE_W-1:0] score_sat;

  assign state = state_q;

  // NOTE: every signal written here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    level_d = level;
    lives_d = lives;
    score_d = score;

    // Kill point and level bonus land in the same update when both occur.
    sum_w = SUM_W'(score) + SUM_W'(kill)
          + (win ? SUM_W'(LEVEL_BONUS) * SUM_W'(level) : '0);
    score_sat = (sum_w > SCORE_MAX_W) ? {SCORE_W{1'b1}} : sum_w[SCORE_W-1:0];

    case (state_q)
      S_START: begin
        if (start) begin
          level_d = 4'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_PLAY;
      S_PLAY: begin
        score_d = score_sat;
        // win outranks tank_destroyed: a simultaneous hit costs no life.
        if (win) begin
          clr_d   = CLR_W'(CLEAR_CYCLES - 1);
          state_d = S_CLEAR;
        end else if (tank_destroyed) begin
          if (lives != 3'd0) lives_d = lives - 3'd1;
          state_d = S_DEATH;
        end
      end
      S_CLEAR: begin
        if (clr_q == '0) begin
          if (level == 4'(NUM_LEVELS)) begin
            state_d = S_SUCCESS;
          end else begin
            level_d = level + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          clr_d = clr_q - CLR_W'(1);
        end
      end
      // lives was already decremented on the way in.
      S_DEATH: state_d = (lives == 3'd0) ? S_FAILED : S_LOAD;
      S_SUCCESS, S_FAILED: begin
        if (start) state_d = S_START;
      end
      default: state_d = S_START;
    endcase

    // START always presents a fresh game, however it was reached.
    if (state_d == S_START) begin
      level_d = 4'd0;
      score_d = '0;
      lives_d = 3'(LIVES);
    end
  end

  // Strobes are decoded from the next state so that every output is a flop
  // that lines up with the state it belongs to.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_START;
      clr_q      <= '0;
      level      <= 4'd0;
      level_load <= 1'b0;
      play_en    <= 1'b0;
      lives      <= 3'(LIVES);
      score      <= '0;
      game_won   <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      level      <= level_d;
      level_load <= (state_d == S_LOAD);
      play_en    <= (state_d == S_PLAY);
      lives      <= lives_d;
      score      <= score_d;
      game_won   <= (state_d == S_SUCCESS);
      game_over  <= (state_d == S_FAILED);
    end
  end

`ifdef SPACE_MONSTERS_HISCORE_EN
  // Score is stable through CLEAR/DEATH, so the current score is the final one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hiscore <= '0;
    end else if ((state_d == S_SUCCESS || state_d == S_FAILED) &&
                 (state_q != state_d) && (score > hiscore)) begin
      hiscore <= score;
    end
  end
`endif

endmodule

// File: tb/tb_space_monsters_game_seq.sv
module tb_space_monsters_game_seq;

  localparam int NUM_LEVELS   = 4;
  localparam int LIVES        = 3;
  localparam int LEVEL_BONUS  = 10;
  localparam int CLEAR_CYCLES = 4;

  // Spec state encodings
  localparam int P_START = 0, P_LOAD = 1, P_PLAY = 2, P_CLEAR = 3,
                 P_DEATH = 4, P_SUCCESS = 5, P_FAILED = 6;

  logic clk, rst, start, kill, win, tank_destroyed;

  logic [3:0] level, level4;
  logic       level_load, level_load4, play_en, play_en4;
  logic [2:0] lives, lives4, state, state4;
  logic [7:0] score;
  logic [3:0] score4;
  logic       game_won, game_won4, game_over, game_over4;
`ifdef SPACE_MONSTERS_HISCORE_EN
  logic [7:0] hiscore;
  logic [3:0] hiscore4;
`endif

  space_monsters_game_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .win(win),
    .tank_destroyed(tank_destroyed), .level(level), .level_load(level_load),
    .play_en(play_en), .lives(lives), .score(score), .game_won(game_won),
    .game_over(game_over), .state(state)
`ifdef SPACE_MONSTERS_HISCORE_EN
    , .hiscore(hiscore)
`endif
  );

  // Narrow-score instance driven in lockstep to exercise saturation at 15.
  space_monsters_game_seq #(.SCORE_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .win(win),
    .tank_destroyed(tank_destroyed), .level(level4), .level_load(level_load4),
    .play_en(play_en4), .lives(lives4), .score(score4), .game_won(game_won4),
    .game_over(game_over4), .state(state4)
`ifdef SPACE_MONSTERS_HISCORE_EN
    , .hiscore(hiscore4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: game rules in plain integers
  int m_ph, m_level, m_lives, m_score, m_score4, m_clear_left, m_hi, m_hi4;

  task automatic model_reset();
    m_ph = P_START; m_level = 0; m_lives = LIVES;
    m_score = 0; m_score4 = 0; m_clear_left = 0; m_hi = 0; m_hi4 = 0;
  endtask

  task automatic model_end(input int ph);
    m_ph = ph;
    if (m_score > m_hi) m_hi = m_score;
    if (m_score4 > m_hi4) m_hi4 = m_score4;
  endtask

  task automatic model_step(input logic s, input logic k, input logic w, input logic t);
    int gain;
    case (m_ph)
      P_START: if (s) begin m_level = 1; m_ph = P_LOAD; end
      P_LOAD:  m_ph = P_PLAY;
      P_PLAY: begin
        gain = int'(k) + (w ? LEVEL_BONUS * m_level : 0);
        m_score  = (m_score + gain > 255) ? 255 : m_score + gain;
        m_score4 = (m_score4 + gain > 15) ? 15 : m_score4 + gain;
        if (w) begin
          m_ph = P_CLEAR;
          m_clear_left = CLEAR_CYCLES;
        end else if (t) begin
          if (m_lives > 0) m_lives--;
          m_ph = P_DEATH;
        end
      end
      P_CLEAR: begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          if (m_level == NUM_LEVELS) model_end(P_SUCCESS);
          else begin m_level++; m_ph = P_LOAD; end
        end
      end
      P_DEATH: if (m_lives == 0) model_end(P_FAILED); else m_ph = P_LOAD;
      default: if (s) begin
        m_ph = P_START; m_level = 0; m_lives = LIVES; m_score = 0; m_score4 = 0;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("state",      32'(state),      32'(m_ph));
    check("level",      32'(level),      32'(m_level));
    check("level_load", 32'(level_load), 32'(m_ph == P_LOAD));
    check("play_en",    32'(play_en),    32'(m_ph == P_PLAY));
    check("lives",      32'(lives),      32'(m_lives));
    check("score",      32'(score),      32'(m_score));
    check("game_won",   32'(game_won),   32'(m_ph == P_SUCCESS));
    check("game_over",  32'(game_over),  32'(m_ph == P_FAILED));
    check("score_w4",   32'(score4),     32'(m_score4));
    check("state_w4",   32'(state4),     32'(m_ph));
`ifdef SPACE_MONSTERS_HISCORE_EN
    check("hiscore",    32'(hiscore),    32'(m_hi));
    check("hiscore_w4", 32'(hiscore4),   32'(m_hi4));
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it.
  task automatic step(input logic r, input logic s, input logic k,
                      input logic w, input logic t);
    rst = r; start = s; kill = k; win = w; tank_destroyed = t;
    @(posedge clk);
    if (!r) model_reset();
    else model_step(s, k, w, t);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; kill = 1'b0; win = 1'b0; tank_destroyed = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    idle(1);

    // Normal play: start, 5 kills, win, wait for level 2 load
    step(1, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    idle(7);

    // Lives: three tank hits in level 1, then start returns to START
    do_reset();
    step(1, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1);
      idle(2);
    end
    idle(2);
    step(1, 1, 0, 0, 0);
    idle(2);

    // Full game, no kills: score 100 and SUCCESS (also the high score)
    do_reset();
    step(1, 1, 0, 0, 0);
    idle(1);
    for (int l = 0; l < NUM_LEVELS; l++) begin
      step(1, 0, 0, 1, 0);
      idle(CLEAR_CYCLES + 1);
    end
    idle(2);

    // Second game ending with 40 in FAILED: high score stays 100
    step(1, 1, 0, 0, 0);
    idle(2);
    step(1, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 30; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    idle(CLEAR_CYCLES + 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1);
      idle(2);
    end
    idle(2);

    // Simultaneous win + tank hit + kill, then reset with clear counter at 2
    do_reset();
    step(1, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 1, 1, 1);
    idle(1);
    step(0, 0, 0, 0, 0);
    idle(2);

    // Saturation: 260 kills then wins on both widths
    step(1, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 260; i++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    idle(CLEAR_CYCLES + 2);
    step(1, 0, 0, 1, 0);
    idle(CLEAR_CYCLES + 2);

    // Randomized play with occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 299) != 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 11) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
